// File: rtl/writeback_commit_rob.sv
// rtl/writeback_commit_rob.sv - round-robin writeback arbiter with in-order commit reorder buffer
module writeback_commit_rob #(
  parameter int p_num_pipes    = 2,
  parameter int p_data_bits    = 32,
  parameter int p_seq_num_bits = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [p_num_pipes-1:0]                Ex_val,
  output logic [p_num_pipes-1:0]                Ex_rdy,
  input  logic [p_num_pipes*p_seq_num_bits-1:0] Ex_seq_num,
  input  logic [p_num_pipes*5-1:0]              Ex_waddr,
  input  logic [p_num_pipes*p_data_bits-1:0]    Ex_wdata,
  input  logic [p_num_pipes-1:0]                Ex_wen,
  output logic [4:0]                            wb_waddr,
  output logic [p_data_bits-1:0]                wb_wdata,
  output logic                                  wb_wen,
  output logic                                  commit_val,
  output logic [p_seq_num_bits-1:0]             commit_seq_num,
  output logic [4:0]                            commit_waddr,
  output logic [p_data_bits-1:0]                commit_wdata,
  output logic                                  commit_wen
);

  localparam int DEPTH = 1 << p_seq_num_bits;
  localparam int PW    = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;
  localparam logic [PW-1:0] LAST_PIPE = PW'(p_num_pipes - 1);

  logic [PW-1:0]             rr_ptr;
  logic [p_num_pipes-1:0]    grant;
  logic [PW-1:0]             grant_idx;
  logic                      any_grant;

  logic [p_seq_num_bits-1:0] sel_seq;
  logic [4:0]                sel_waddr;
  logic [p_data_bits-1:0]    sel_wdata;
  logic                      sel_wen;

  logic [DEPTH-1:0]          valid;
  logic [DEPTH-1:0]          rob_wen;
  logic [4:0]                rob_waddr [DEPTH];
  logic [p_data_bits-1:0]    rob_wdata [DEPTH];
  logic [p_seq_num_bits-1:0] head;

  // Pick the first requesting pipe at or after rr_ptr; nothing is granted while in reset.
  always_comb begin
    int            idx;
    logic [PW-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < p_num_pipes; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= p_num_pipes) idx = idx - p_num_pipes;
      cand = PW'(idx);
      if (!any_grant && !rst && Ex_val[cand]) begin
        any_grant   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  assign Ex_rdy    = grant;
  assign sel_seq   = Ex_seq_num[grant_idx*p_seq_num_bits +: p_seq_num_bits];
  assign sel_waddr = Ex_waddr[grant_idx*5 +: 5];
  assign sel_wdata = Ex_wdata[grant_idx*p_data_bits +: p_data_bits];
  assign sel_wen   = Ex_wen[grant_idx];

  // Priority pointer moves just past the pipe that won; it stays put on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= (grant_idx == LAST_PIPE) ? '0 : grant_idx + 1'b1;
    end
  end

  // Writeback stage register; address/data hold on idle cycles, only wb_wen drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_wen   <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
    end else if (any_grant) begin
      wb_wen   <= sel_wen;
      wb_waddr <= sel_waddr;
      wb_wdata <= sel_wdata;
    end else begin
      wb_wen   <= 1'b0;
    end
  end

  // Valid bits and head: commit clears the head slot first, an accept then marks its slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      head  <= '0;
    end else begin
      logic [DEPTH-1:0] valid_n;
      valid_n = valid;
      if (commit_val) begin
        valid_n[head] = 1'b0;
        head          <= head + 1'b1;
      end
      if (any_grant) valid_n[sel_seq] = 1'b1;
      valid <= valid_n;
    end
  end

  // ROB payload needs no reset: a slot is only observed while its valid bit is set.
  always_ff @(posedge clk) begin
    if (any_grant) begin
      rob_waddr[sel_seq] <= sel_waddr;
      rob_wdata[sel_seq] <= sel_wdata;
      rob_wen[sel_seq]   <= sel_wen;
    end
  end

  assign commit_val     = valid[head];
  assign commit_seq_num = head;
  assign commit_waddr   = rob_waddr[head];
  assign commit_wdata   = rob_wdata[head];
  assign commit_wen     = rob_wen[head];

  // Upstream must never reuse a sequence number whose slot has not committed yet.
  assert property (@(posedge clk) disable iff (rst) any_grant |-> !valid[sel_seq]);

endmodule

// File: tb/tb_writeback_commit_rob.sv
// tb/tb_writeback_commit_rob.sv - self-checking bench for writeback_commit_rob
module tb_writeback_commit_rob;

  localparam int NP    = 2;
  localparam int DB    = 32;
  localparam int SB    = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    Ex_val, Ex_rdy, Ex_wen;
  logic [NP*SB-1:0] Ex_seq_num;
  logic [NP*5-1:0]  Ex_waddr;
  logic [NP*DB-1:0] Ex_wdata;
  logic [4:0]       wb_waddr, commit_waddr;
  logic [DB-1:0]    wb_wdata, commit_wdata;
  logic             wb_wen, commit_val, commit_wen;
  logic [SB-1:0]    commit_seq_num;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  writeback_commit_rob #(.p_num_pipes(NP), .p_data_bits(DB), .p_seq_num_bits(SB)) dut (
    .clk(clk), .rst(rst),
    .Ex_val(Ex_val), .Ex_rdy(Ex_rdy), .Ex_seq_num(Ex_seq_num),
    .Ex_waddr(Ex_waddr), .Ex_wdata(Ex_wdata), .Ex_wen(Ex_wen),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_wen(wb_wen),
    .commit_val(commit_val), .commit_seq_num(commit_seq_num),
    .commit_waddr(commit_waddr), .commit_wdata(commit_wdata), .commit_wen(commit_wen)
  );

  // Reference model: a pointer, a slot array and a head counter.
  int            m_ptr, m_head, m_last_g, m_commits;
  logic          m_valid [DEPTH];
  logic [4:0]    m_addr  [DEPTH];
  logic [DB-1:0] m_data  [DEPTH];
  logic          m_wen   [DEPTH];
  logic          m_wb_wen;
  logic [4:0]    m_wb_addr;
  logic [DB-1:0] m_wb_data;
  logic [NP-1:0] last_rdy;
  int            commit_log [$];

  typedef struct {
    logic v; logic [SB-1:0] s; logic [4:0] a; logic [DB-1:0] d; logic e;
    logic [NP-1:0] x_rdy; logic x_wbwen; logic [4:0] x_wba; logic [DB-1:0] x_wbd;
    logic x_cv; logic [SB-1:0] x_cs; logic [4:0] x_ca; logic [DB-1:0] x_cd; logic x_ce;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_head = 0; m_last_g = -1; m_commits = 0;
    m_wb_wen = 1'b0; m_wb_addr = '0; m_wb_data = '0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  task automatic set_pipe(int p, logic v, logic [SB-1:0] s, logic [4:0] a, logic [DB-1:0] d, logic e);
    Ex_val[p]            = v;
    Ex_seq_num[p*SB +: SB] = s;
    Ex_waddr[p*5 +: 5]   = a;
    Ex_wdata[p*DB +: DB] = d;
    Ex_wen[p]            = e;
  endtask

  task automatic idle_all();
    Ex_val = '0; Ex_seq_num = '0; Ex_waddr = '0; Ex_wdata = '0; Ex_wen = '0;
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NP; k++) begin
      int i;
      i = (m_ptr + k) % NP;
      if (Ex_val[i]) return i;
    end
    return -1;
  endfunction

  // One clock cycle: compare at the falling edge, then advance the model past the rising edge.
  task automatic step();
    int            g;
    int            s;
    logic [NP-1:0] exp_rdy;
    @(negedge clk);
    g = model_grant();
    exp_rdy = (g >= 0) ? NP'(1 << g) : '0;
    last_rdy = Ex_rdy;
    chk("ex_rdy", 64'(Ex_rdy), 64'(exp_rdy));
    chk("wb_wen", 64'(wb_wen), 64'(m_wb_wen));
    chk("wb_waddr", 64'(wb_waddr), 64'(m_wb_addr));
    chk("wb_wdata", 64'(wb_wdata), 64'(m_wb_data));
    chk("commit_val", 64'(commit_val), 64'(m_valid[m_head]));
    chk("commit_seq", 64'(commit_seq_num), 64'(m_head));
    if (m_valid[m_head]) begin
      chk("commit_waddr", 64'(commit_waddr), 64'(m_addr[m_head]));
      chk("commit_wdata", 64'(commit_wdata), 64'(m_data[m_head]));
      chk("commit_wen", 64'(commit_wen), 64'(m_wen[m_head]));
    end
    if (commit_val) commit_log.push_back(int'(commit_seq_num));
    @(posedge clk);
    if (m_valid[m_head]) begin
      m_valid[m_head] = 1'b0;
      m_head = (m_head + 1) % DEPTH;
      m_commits++;
    end
    m_last_g = g;
    if (g >= 0) begin
      s = int'(Ex_seq_num[g*SB +: SB]);
      m_valid[s] = 1'b1;
      m_addr[s]  = Ex_waddr[g*5 +: 5];
      m_data[s]  = Ex_wdata[g*DB +: DB];
      m_wen[s]   = Ex_wen[g];
      m_wb_wen   = Ex_wen[g];
      m_wb_addr  = Ex_waddr[g*5 +: 5];
      m_wb_data  = Ex_wdata[g*DB +: DB];
      m_ptr      = (g + 1) % NP;
    end else begin
      m_wb_wen = 1'b0;
    end
    #1;
  endtask

  // Called just after a rising edge; leaves the DUT out of reset and the model cleared.
  task automatic apply_reset();
    idle_all();
    rst = 1'b1;
    #2;
    chk("rst_wb_wen", 64'(wb_wen), 64'd0);
    chk("rst_commit_val", 64'(commit_val), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic          pend [NP];
    logic [SB-1:0] pseq [NP];
    logic [4:0]    paddr [NP];
    logic [DB-1:0] pdata [NP];
    logic          pwen [NP];
    int            nxt, alloc_total;
    logic [SB-1:0] seq_q [NP];

    // Directed vector table: pipe 0 only; in-order, out-of-order, idle hold and wen=0.
    tbl[0] = '{1'b1, 4'd0, 5'd5, 32'hA,  1'b1, 2'b01, 1'b0, 5'd0, 32'h0,  1'b0, 4'd0, 5'd0, 32'h0,  1'b0};
    tbl[1] = '{1'b1, 4'd1, 5'd6, 32'hB,  1'b1, 2'b01, 1'b1, 5'd5, 32'hA,  1'b1, 4'd0, 5'd5, 32'hA,  1'b1};
    tbl[2] = '{1'b1, 4'd3, 5'd3, 32'h11, 1'b1, 2'b01, 1'b1, 5'd6, 32'hB,  1'b1, 4'd1, 5'd6, 32'hB,  1'b1};
    tbl[3] = '{1'b1, 4'd2, 5'd2, 32'h22, 1'b1, 2'b01, 1'b1, 5'd3, 32'h11, 1'b0, 4'd2, 5'd0, 32'h0,  1'b0};
    tbl[4] = '{1'b0, 4'd0, 5'd0, 32'h0,  1'b0, 2'b00, 1'b1, 5'd2, 32'h22, 1'b1, 4'd2, 5'd2, 32'h22, 1'b1};
    tbl[5] = '{1'b0, 4'd0, 5'd0, 32'h0,  1'b0, 2'b00, 1'b0, 5'd2, 32'h22, 1'b1, 4'd3, 5'd3, 32'h11, 1'b1};
    tbl[6] = '{1'b1, 4'd4, 5'd7, 32'h33, 1'b0, 2'b01, 1'b0, 5'd2, 32'h22, 1'b0, 4'd4, 5'd0, 32'h0,  1'b0};
    tbl[7] = '{1'b0, 4'd0, 5'd0, 32'h0,  1'b0, 2'b00, 1'b0, 5'd7, 32'h33, 1'b1, 4'd4, 5'd7, 32'h33, 1'b0};
    tbl[8] = '{1'b0, 4'd0, 5'd0, 32'h0,  1'b0, 2'b00, 1'b0, 5'd7, 32'h33, 1'b0, 4'd5, 5'd0, 32'h0,  1'b0};

    // Reset with both pipes requesting: nothing granted, outputs at reset values.
    rst = 1'b1;
    idle_all();
    Ex_val = 2'b11;
    #2;
    chk("reset_ex_rdy", 64'(Ex_rdy), 64'd0);
    chk("reset_wb_wen", 64'(wb_wen), 64'd0);
    chk("reset_wb_waddr", 64'(wb_waddr), 64'd0);
    chk("reset_wb_wdata", 64'(wb_wdata), 64'd0);
    chk("reset_commit_val", 64'(commit_val), 64'd0);
    chk("reset_commit_seq", 64'(commit_seq_num), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("first_grant_pipe0", 64'(Ex_rdy), 64'b01);
    idle_all();

    for (int r = 0; r < 9; r++) begin
      set_pipe(0, tbl[r].v, tbl[r].s, tbl[r].a, tbl[r].d, tbl[r].e);
      @(negedge clk);
      chk($sformatf("tbl%0d_ex_rdy", r), 64'(Ex_rdy), 64'(tbl[r].x_rdy));
      chk($sformatf("tbl%0d_wb_wen", r), 64'(wb_wen), 64'(tbl[r].x_wbwen));
      chk($sformatf("tbl%0d_wb_waddr", r), 64'(wb_waddr), 64'(tbl[r].x_wba));
      chk($sformatf("tbl%0d_wb_wdata", r), 64'(wb_wdata), 64'(tbl[r].x_wbd));
      chk($sformatf("tbl%0d_commit_val", r), 64'(commit_val), 64'(tbl[r].x_cv));
      chk($sformatf("tbl%0d_commit_seq", r), 64'(commit_seq_num), 64'(tbl[r].x_cs));
      if (tbl[r].x_cv) begin
        chk($sformatf("tbl%0d_commit_waddr", r), 64'(commit_waddr), 64'(tbl[r].x_ca));
        chk($sformatf("tbl%0d_commit_wdata", r), 64'(commit_wdata), 64'(tbl[r].x_cd));
        chk($sformatf("tbl%0d_commit_wen", r), 64'(commit_wen), 64'(tbl[r].x_ce));
      end
      @(posedge clk);
      #1;
    end

    // Round-robin: both pipes request for four cycles, then pipe 1 alone.
    apply_reset();
    seq_q[0] = 4'd0; seq_q[1] = 4'd1; nxt = 2;
    for (int i = 0; i < 4; i++) begin
      set_pipe(0, 1'b1, seq_q[0], 5'(10 + i), 32'h100 + 32'(i), 1'b1);
      set_pipe(1, 1'b1, seq_q[1], 5'(20 + i), 32'h200 + 32'(i), 1'b1);
      step();
      chk($sformatf("rr_both_%0d", i), 64'(last_rdy), (i % 2 == 0) ? 64'b01 : 64'b10);
      for (int p = 0; p < NP; p++)
        if (last_rdy[p]) begin seq_q[p] = SB'(nxt); nxt++; end
    end
    for (int i = 0; i < 3; i++) begin
      set_pipe(0, 1'b0, '0, '0, '0, 1'b0);
      set_pipe(1, 1'b1, seq_q[1], 5'(25 + i), 32'h300 + 32'(i), 1'b1);
      step();
      chk($sformatf("rr_pipe1_only_%0d", i), 64'(last_rdy), 64'b10);
      if (last_rdy[1]) begin seq_q[1] = SB'(nxt); nxt++; end
    end

    // Wrap-around: seq 0..15 then 0..3 in order on pipe 0.
    apply_reset();
    commit_log.delete();
    for (int i = 0; i < 20; i++) begin
      set_pipe(0, 1'b1, SB'(i % DEPTH), 5'((i + 1) % 32), $urandom, 1'b1);
      step();
    end
    idle_all();
    step();
    step();
    chk("wrap_commit_count", 64'(commit_log.size()), 64'd20);
    for (int j = 0; j < 20 && j < commit_log.size(); j++)
      chk($sformatf("wrap_commit_seq_%0d", j), 64'(commit_log[j]), 64'(j % DEPTH));
    chk("wrap_head_after", 64'(commit_seq_num), 64'd4);

    // Non-writing result, then a reset while seq 2 waits behind missing seq 1.
    apply_reset();
    set_pipe(0, 1'b1, 4'd0, 5'd9, 32'hDEAD, 1'b0);
    step();
    idle_all();
    @(negedge clk);
    chk("nowrite_wb_wen", 64'(wb_wen), 64'd0);
    chk("nowrite_commit_val", 64'(commit_val), 64'd1);
    chk("nowrite_commit_wen", 64'(commit_wen), 64'd0);
    @(posedge clk); #1;
    m_valid[0] = 1'b0; m_head = 1; m_wb_wen = 1'b0; m_wb_addr = 5'd9; m_wb_data = 32'hDEAD;
    chk("nowrite_head_adv", 64'(commit_seq_num), 64'd1);
    set_pipe(0, 1'b1, 4'd2, 5'd4, 32'h44, 1'b1);
    step();
    idle_all();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_commit_val", 64'(commit_val), 64'd0);
    chk("midrst_wb_wen", 64'(wb_wen), 64'd0);
    chk("midrst_head", 64'(commit_seq_num), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("postrst_no_commit_%0d", i), 64'(commit_val), 64'd0);
    end

    // Randomised traffic against the model; sequence numbers allocated in program order.
    apply_reset();
    alloc_total = 0;
    for (int p = 0; p < NP; p++) pend[p] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!pend[p] && (alloc_total - m_commits) < DEPTH && $urandom_range(0, 1) == 1) begin
          pend[p]  = 1'b1;
          pseq[p]  = SB'(alloc_total % DEPTH);
          paddr[p] = 5'($urandom);
          pdata[p] = $urandom;
          pwen[p]  = 1'($urandom);
          alloc_total++;
        end
        set_pipe(p, pend[p] && ($urandom_range(0, 3) != 0), pseq[p], paddr[p], pdata[p], pwen[p]);
      end
      step();
      if (m_last_g >= 0) pend[m_last_g] = 1'b0;
    end
    for (int p = 0; p < NP; p++)
      set_pipe(p, pend[p], pseq[p], paddr[p], pdata[p], pwen[p]);
    for (int c = 0; c < 4; c++) begin
      step();
      if (m_last_g >= 0) begin
        pend[m_last_g] = 1'b0;
        Ex_val[m_last_g] = 1'b0;
      end
    end
    idle_all();
    for (int c = 0; c < DEPTH + 2; c++) step();
    chk("random_all_committed", 64'(m_commits), 64'(alloc_total));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
